pcs_block_lock_fsm: RTL

Receive-side 64b/66b block-lock controller for the 10G PCS. It watches the 2-bit sync header of each 66-bit block coming out of the RX gearbox and decides when the header alignment is trustworthy. While alignment is bad it commands the gearbox to slip by one bit. It drives the block-lock flag consumed by the descrambler and the XGMII decoder (`i_block_lock`). The lock algorithm follows IEEE 802.3 Clause 49 lock_state: 64 consecutive valid headers to lock; 16 invalid headers within a 64-header window to lose lock.

---
 rtl/pcs_pkg.sv | 37 +++
 rtl/pcs_block_lock_fsm.sv | 118 +++++++++++
 2 files changed

// File: rtl/pcs_pkg.sv
// Shared 10G PCS definitions: block-lock state encoding, sync-header values,
// and the 64b/66b block-type field values used by the XGMII encoder/decoder.
package pcs_pkg;

  // Block-lock controller states
  typedef enum logic {
    TEST_SH   = 1'b0,
    SLIP_WAIT = 1'b1
  } lock_state_t;

  // 66-bit block sync headers
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Block-type field values for control blocks
  localparam logic [7:0] BT_C8    = 8'h1e;
  localparam logic [7:0] BT_C4_O4 = 8'h2d;
  localparam logic [7:0] BT_C4_S4 = 8'h33;
  localparam logic [7:0] BT_O4_S4 = 8'h66;
  localparam logic [7:0] BT_O4_C4 = 8'h4b;
  localparam logic [7:0] BT_O4_O4 = 8'h55;
  localparam logic [7:0] BT_S0    = 8'h78;
  localparam logic [7:0] BT_T0    = 8'h87;
  localparam logic [7:0] BT_T1    = 8'h99;
  localparam logic [7:0] BT_T2    = 8'haa;
  localparam logic [7:0] BT_T3    = 8'hb4;
  localparam logic [7:0] BT_T4    = 8'hcc;
  localparam logic [7:0] BT_T5    = 8'hd2;
  localparam logic [7:0] BT_T6    = 8'he1;
  localparam logic [7:0] BT_T7    = 8'hff;

  // A sync header is usable only if it marks a data or a control block
  function automatic logic is_valid_sync(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_block_lock_fsm.sv
// 64b/66b receive block-lock controller. Counts sync headers in windows,
// declares lock after a clean window, drops lock after too many bad headers
// in one window, and asks the gearbox to slip one bit while alignment is bad.
module pcs_block_lock_fsm #(
  parameter int HDR_WIDTH      = 2,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVLD_MAX   = 16,
  parameter int SLIP_WAIT      = 8,
  parameter int LOSS_CNT_WIDTH = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [HDR_WIDTH-1:0]      i_rx_hdr,
  input  logic                      i_rx_hdr_valid,
  output logic                      o_block_lock,
  output logic                      o_slip,
  output logic [LOSS_CNT_WIDTH-1:0] o_lock_loss_cnt
);

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SH_CNT_MAX);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(SH_INVLD_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  pcs_pkg::lock_state_t state_q, state_d;
  logic [CNT_W-1:0]          sh_cnt_q, sh_cnt_d;
  logic [INV_W-1:0]          sh_invld_cnt_q, sh_invld_cnt_d;
  logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic                      block_lock_d;
  logic                      slip_d;
  logic [LOSS_CNT_WIDTH-1:0] loss_cnt_d;

  logic             hdr_invalid;
  logic [CNT_W-1:0] n_cnt;
  logic [INV_W-1:0] n_inv;

  assign hdr_invalid = (i_rx_hdr != HDR_WIDTH'(pcs_pkg::SYNC_DATA)) &&
                       (i_rx_hdr != HDR_WIDTH'(pcs_pkg::SYNC_CTRL));
  assign n_cnt       = sh_cnt_q + CNT_W'(1);
  assign n_inv       = sh_invld_cnt_q + INV_W'(hdr_invalid);

  // Next-state and next-output computation for the lock FSM
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d        = state_q;
    sh_cnt_d       = sh_cnt_q;
    sh_invld_cnt_d = sh_invld_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    block_lock_d   = o_block_lock;
    slip_d         = 1'b0;
    loss_cnt_d     = o_lock_loss_cnt;

    case (state_q)
      pcs_pkg::TEST_SH: begin
        if (i_rx_hdr_valid) begin
          if (hdr_invalid && ((n_inv == INV_LAST) || !o_block_lock)) begin
            // Alignment is bad: drop lock and slip the gearbox one bit
            block_lock_d   = 1'b0;
            slip_d         = 1'b1;
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
            wait_cnt_d     = '0;
            state_d        = pcs_pkg::SLIP_WAIT;
          end else if (n_cnt == CNT_LAST) begin
            // Window closes; only a completely clean window grants lock
            sh_cnt_d       = '0;
            sh_invld_cnt_d = '0;
            if (n_inv == '0) block_lock_d = 1'b1;
          end else begin
            sh_cnt_d       = n_cnt;
            sh_invld_cnt_d = n_inv;
          end
        end
      end
      pcs_pkg::SLIP_WAIT: begin
        // Headers are ignored while the gearbox settles on the new alignment
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          state_d    = pcs_pkg::TEST_SH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
    endcase

    // Count each loss of lock, holding at all-ones
    if (o_block_lock && !block_lock_d && (o_lock_loss_cnt != '1))
      loss_cnt_d = o_lock_loss_cnt + LOSS_CNT_WIDTH'(1);
  end

  // State, counter and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= pcs_pkg::TEST_SH;
      sh_cnt_q        <= '0;
      sh_invld_cnt_q  <= '0;
      wait_cnt_q      <= '0;
      o_block_lock    <= 1'b0;
      o_slip          <= 1'b0;
      o_lock_loss_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q         <= state_d;
      sh_cnt_q        <= sh_cnt_d;
      sh_invld_cnt_q  <= sh_invld_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
      o_block_lock    <= block_lock_d;
      o_slip          <= slip_d;
      o_lock_loss_cnt <= loss_cnt_d;
    end
  end

endmodule
